// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync-window helpers and raster types
// for the VGA timing generator and the renderers that consume its outputs.
package vga_timing_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Sync pulse occupies [start, end) in counter space.
  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned front);
    return visible + front;
  endfunction

  function automatic int unsigned sync_end(input int unsigned visible,
                                           input int unsigned front,
                                           input int unsigned width);
    return visible + front + width;
  endfunction

  localparam int unsigned HS_START = sync_start(VGA_H_VISIBLE, VGA_H_FRONT);
  localparam int unsigned HS_END   = sync_end(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC);
  localparam int unsigned VS_START = sync_start(VGA_V_VISIBLE, VGA_V_FRONT);
  localparam int unsigned VS_END   = sync_end(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC);

  function automatic logic in_window(input coord_t pos,
                                     input int unsigned first,
                                     input int unsigned last_excl);
    return (32'(pos) >= first) && (32'(pos) < last_excl);
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic frame_clk;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, frame_clk: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for side-band signals that must stay aligned
// with a pipelined pixel path; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int unsigned          WIDTH     = 1,
  parameter int unsigned          DEPTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign q_o = d_i;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_q;
        logic [WIDTH-1:0] stage_d;

        if (gi == 0) begin : g_first
          assign stage_d = d_i;
        end else begin : g_next
          assign stage_d = g_stage[gi-1].stage_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            stage_q <= RESET_VAL;
          end else begin
            stage_q <= stage_d;
          end
        end
      end
      assign q_o = g_stage[DEPTH-1].stage_q;
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: free-running pixel/line counters, active-video and
// sync decode, and sync outputs delayed to match renderer colour latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        blank_d,
  output logic        hs,
  output logic        vs,
  output logic        frame_clk,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t      H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_LAST  = coord_t'(V_TOTAL - 1);
  localparam int unsigned HS_LO   = sync_start(H_VISIBLE, H_FRONT);
  localparam int unsigned HS_HI   = sync_end(H_VISIBLE, H_FRONT, H_SYNC);
  localparam int unsigned VS_LO   = sync_start(V_VISIBLE, V_FRONT);
  localparam int unsigned VS_HI   = sync_end(V_VISIBLE, V_FRONT, V_SYNC);

  generate
    if (SYNC_DELAY > 7) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
    end
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
      $error("vga_timing_gen: totals exceed coordinate width");
    end
  endgenerate

  coord_t      h_q, h_d;
  coord_t      v_q, v_d;
  logic        run_q, run_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        line_end;
  logic        frame_end;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      run_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      run_q         <= run_d;
      frame_count_q <= frame_count_d;
    end
  end

  // The first cycle after release only arms run; counting starts the cycle after,
  // so the first emitted pixel is always (0,0) of a full frame.
  always_comb begin
    line_end      = (h_q == H_LAST);
    frame_end     = line_end && (v_q == V_LAST);
    run_d         = 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    frame_count_d = frame_count_q;
    if (run_q) begin
      h_d = line_end ? '0 : h_q + coord_t'(1);
      if (line_end) begin
        v_d = frame_end ? '0 : v_q + coord_t'(1);
      end
      if (frame_end) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
  end

  logic      hs_raw;
  logic      vs_raw;
  logic      blank_raw;
  sync_bus_t sync_raw;
  sync_bus_t sync_dly;

  always_comb begin
    blank_raw = run_q && (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
    hs_raw    = !in_window(h_q, HS_LO, HS_HI);
    vs_raw    = !in_window(v_q, VS_LO, VS_HI);
    sync_raw  = '{hs: hs_raw, vs: vs_raw, blank: blank_raw, frame_clk: !vs_raw};
  end

  sync_delay_line #(
    .WIDTH     ($bits(sync_bus_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    (sync_raw),
    .q_o    (sync_dly)
  );

  assign DrawX       = h_q;
  assign DrawY       = v_q;
  assign blank       = blank_raw;
  assign frame_start = run_q && (h_q == '0) && (v_q == '0);
  assign frame_count = frame_count_q;
  assign hs          = sync_dly.hs;
  assign vs          = sync_dly.vs;
  assign blank_d     = sync_dly.blank;
  assign frame_clk   = sync_dly.frame_clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so several whole frames
// fit in a short run; one instance with a 2-stage sync delay, one with none.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HSY = 6, HB = 5;
  localparam int VV = 10, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  a_x, a_y, b_x, b_y;
  logic        a_bl, a_bd, a_hs, a_vs, a_fk, a_fs;
  logic        b_bl, b_bd, b_hs, b_vs, b_fk, b_fs;
  logic [15:0] a_fc, b_fc;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_DELAY(2)
  ) u_dut_d2 (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
    .blank_d(a_bd), .hs(a_hs), .vs(a_vs), .frame_clk(a_fk),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_DELAY(0)
  ) u_dut_d0 (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
    .blank_d(b_bd), .hs(b_hs), .vs(b_vs), .frame_clk(b_fk),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  int total = 0;
  int bad   = 0;
  int c     = 0;   // rising edges since the last reset release
  int gcyc  = 0;

  logic hs_prev, vs_prev, fk_prev;
  bit   hs_armed, vs_armed, fk_armed;
  int   hs_last_fall, hs_low, vs_low, fk_last_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference raster: after c edges the scan has advanced c-1 pixels.
  function automatic int ref_h(input int k);
    return (k < 1) ? 0 : (k - 1) % HT;
  endfunction
  function automatic int ref_v(input int k);
    return (k < 1) ? 0 : ((k - 1) / HT) % VT;
  endfunction

  // {hs, vs, blank, frame_clk} as decoded from the raster at edge count k
  function automatic logic [3:0] ref_raw(input int k);
    int h, v;
    logic hsr, vsr, bl;
    if (k < 1) return 4'b1100;
    h   = ref_h(k);
    v   = ref_v(k);
    bl  = (h < HV) && (v < VV);
    hsr = !((h >= HV + HF) && (h < HV + HF + HSY));
    vsr = !((v >= VV + VF) && (v < VV + VF + VSY));
    return {hsr, vsr, bl, !vsr};
  endfunction

  task automatic check_dut(input string nm, input int d,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic bl, input logic fs, input logic [15:0] fc,
                           input logic hs, input logic vs, input logic bd,
                           input logic fk);
    int eh, ev, efc;
    logic ebl, efs;
    logic [3:0] rw;
    eh  = ref_h(c);
    ev  = ref_v(c);
    ebl = (c >= 1) && (eh < HV) && (ev < VV);
    efs = (c >= 1) && (eh == 0) && (ev == 0);
    efc = (c < 1) ? 0 : ((c - 1) / FRAME) & 16'hFFFF;
    rw  = ref_raw(c - d);
    check($sformatf("%s.DrawX@c%0d", nm, c), 32'(x), 32'(eh));
    check($sformatf("%s.DrawY@c%0d", nm, c), 32'(y), 32'(ev));
    check($sformatf("%s.blank@c%0d", nm, c), 32'(bl), 32'(ebl));
    check($sformatf("%s.frame_start@c%0d", nm, c), 32'(fs), 32'(efs));
    check($sformatf("%s.frame_count@c%0d", nm, c), 32'(fc), 32'(efc));
    check($sformatf("%s.hs@c%0d", nm, c), 32'(hs), 32'(rw[3]));
    check($sformatf("%s.vs@c%0d", nm, c), 32'(vs), 32'(rw[2]));
    check($sformatf("%s.blank_d@c%0d", nm, c), 32'(bd), 32'(rw[1]));
    check($sformatf("%s.frame_clk@c%0d", nm, c), 32'(fk), 32'(rw[0]));
  endtask

  task automatic check_all();
    check_dut("d2", 2, a_x, a_y, a_bl, a_fs, a_fc, a_hs, a_vs, a_bd, a_fk);
    check_dut("d0", 0, b_x, b_y, b_bl, b_fs, b_fc, b_hs, b_vs, b_bd, b_fk);
  endtask

  task automatic clear_tracking();
    hs_prev  = 1'b1;
    vs_prev  = 1'b1;
    fk_prev  = 1'b0;
    hs_armed = 1'b0;
    vs_armed = 1'b0;
    fk_armed = 1'b0;
    hs_low   = 0;
    vs_low   = 0;
  endtask

  // Pulse widths and periods on the delayed outputs, independent of the raster model
  task automatic measure();
    gcyc++;
    if (hs_prev && !a_hs) begin
      if (hs_armed) check("hs_period", 32'(gcyc - hs_last_fall), 32'(HT));
      hs_armed     = 1'b1;
      hs_last_fall = gcyc;
      hs_low       = 0;
    end
    if (!a_hs) hs_low++;
    if (!hs_prev && a_hs && hs_armed) check("hs_width", 32'(hs_low), 32'(HSY));
    if (vs_prev && !a_vs) begin
      vs_armed = 1'b1;
      vs_low   = 0;
    end
    if (!a_vs) vs_low++;
    if (!vs_prev && a_vs && vs_armed) check("vs_width", 32'(vs_low), 32'(HT * VSY));
    if (!fk_prev && a_fk) begin
      if (fk_armed) check("frame_clk_period", 32'(gcyc - fk_last_rise), 32'(FRAME));
      fk_armed     = 1'b1;
      fk_last_rise = gcyc;
    end
    hs_prev = a_hs;
    vs_prev = a_vs;
    fk_prev = a_fk;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      check_all();
      measure();
    end
  endtask

  task automatic reset_and_restart(input int hold);
    rst_n = 1'b0;
    #1;
    c = 0;
    check_all();
    clear_tracking();
    repeat (hold) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    clear_tracking();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    c = 0;
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();

    // Three whole frames plus the wrap into a fourth
    run_cycles(3 * FRAME + 40);

    // Directed mid-frame reset at a visible pixel, then randomly placed ones
    for (int i = 0; i < FRAME && !(ref_h(c) == 7 && ref_v(c) == 4); i++) run_cycles(1);
    check("reset_point_x", 32'(a_x), 32'd7);
    reset_and_restart(2);
    run_cycles(FRAME + 30);

    for (int r = 0; r < 3; r++) begin
      run_cycles($urandom_range(20, FRAME));
      reset_and_restart($urandom_range(1, 4));
      run_cycles($urandom_range(10, 2 * FRAME));
    end

    run_cycles(FRAME + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
